div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU.
- EX initiates a divide; this block responds with `{remainder, quotient}` and a ready flag.
- EX holds the pipeline stalled through the stall controller while the divide is in progress, then writes the result to HI/LO.
- Restoring shift-subtract algorithm, one quotient bit per clock.

---
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock; result is {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_annul,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_opdata1,
  input  logic [DATA_W-1:0]     i_opdata2,
  output logic [2*DATA_W-1:0]   o_result,
  output logic                  o_ready
);

  typedef enum logic [1:0] {
    FREE,
    BY_ZERO,
    ON,
    END
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W:0]   shifted;
  logic              take;
  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] quo_n;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  // dvd doubles as the quotient shift register as dividend bits leave it
  always_comb begin
    shifted = {rem, dvd[DATA_W-1]};
    take    = shifted >= {1'b0, dsr};
    rem_n   = take ? shifted[DATA_W-1:0] - dsr
                   : shifted[DATA_W-1:0];
    quo_n   = {dvd[DATA_W-2:0], take};
    q_fix   = neg_q ? -quo_n : quo_n;
    r_fix   = neg_r ? -rem_n : rem_n;
    a_neg   = i_signed & i_opdata1[DATA_W-1];
    b_neg   = i_signed & i_opdata2[DATA_W-1];
    a_mag   = a_neg ? -i_opdata1 : i_opdata1;
    b_mag   = b_neg ? -i_opdata2 : i_opdata2;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FREE;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_ready  <= 1'b0;
      o_result <= '0;
    end else begin
      unique case (state)
        FREE: begin
          o_ready  <= 1'b0;
          o_result <= '0;
          if (i_start && !i_annul) begin
            if (i_opdata2 == '0) begin
              state <= BY_ZERO;
            end else begin
              state <= ON;
              rem   <= '0;
              dvd   <= a_mag;
              dsr   <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
            end
          end
        end
        BY_ZERO: begin
          state    <= END;
          o_ready  <= 1'b1;
          o_result <= '0;
        end
        ON: begin
          if (i_annul) begin
            state    <= FREE;
            o_ready  <= 1'b0;
            o_result <= '0;
          end else begin
            rem <= rem_n;
            dvd <= quo_n;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state    <= END;
              o_ready  <= 1'b1;
              o_result <= {r_fix, q_fix};
            end
          end
        end
        END: begin
          if (!i_start) begin
            state    <= FREE;
            o_ready  <= 1'b0;
            o_result <= '0;
          end
        end
        default: begin
          state    <= FREE;
          o_ready  <= 1'b0;
          o_result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks for div_unit with an expected-result queue.
// Results and latencies are predicted by the bench when each divide starts.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_annul;
  logic        i_signed;
  logic [31:0] i_opdata1;
  logic [31:0] i_opdata2;
  logic [63:0] o_result;
  logic        o_ready;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_annul   (i_annul),
    .i_signed  (i_signed),
    .i_opdata1 (i_opdata1),
    .i_opdata2 (i_opdata2),
    .o_result  (o_result),
    .o_ready   (o_ready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a divide, waits for o_ready, checks latency, result,
  // hold behaviour and the clear after start drops.
  // chg >= 0 scrambles the operand inputs after that many edges.
  task automatic do_div(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic sgn,
                        input logic [63:0] exp,
                        input int hold,
                        input int chg);
    int n;
    logic [63:0] e;
    int l;
    exp_q.push_back(exp);
    lat_q.push_back((b == 32'd0) ? 1 : 32);
    @(negedge clk);
    i_opdata1 = a;
    i_opdata2 = b;
    i_signed  = sgn;
    i_start   = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == chg) begin
        i_opdata1 = ~i_opdata1;
        i_opdata2 = $urandom | 32'd1;
        i_signed  = ~i_signed;
      end
      if (o_ready) break;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'(l));
    chk({tag, "_res"}, o_result, e);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, {o_ready, o_result[62:0]},
          {1'b1, e[62:0]});
    end
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_clr"}, {63'd0, o_ready}, 64'd0);
    chk({tag, "_clr_res"}, o_result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        seen;

    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_annul   = 1'b0;
    i_signed  = 1'b0;
    i_opdata1 = 32'd0;
    i_opdata2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, o_ready}, 64'd0);
    chk("rst_res", o_result, 64'd0);
    @(negedge clk);
    i_rst = 1'b0;

    do_div("u100_7", 32'd100, 32'd7, 1'b0,
           64'h00000002_0000000E, 5, -1);
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
           64'hFFFFFFFF_FFFFFFFD, 1, -1);
    do_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
           64'h00000001_FFFFFFFD, 1, -1);
    do_div("by_zero", 32'd5, 32'd0, 1'b0,
           64'd0, 2, -1);
    do_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
           64'h00000000_80000000, 1, -1);

    // annul partway through
    @(negedge clk);
    i_opdata1 = 32'hFFFFFFFF;
    i_opdata2 = 32'd3;
    i_signed  = 1'b0;
    i_start   = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    i_annul = 1'b1;
    i_start = 1'b0;
    @(posedge clk);
    #1;
    chk("annul_ready", {63'd0, o_ready}, 64'd0);
    @(negedge clk);
    i_annul = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_ready || o_result != 64'd0) seen = 1'b1;
    end
    chk("annul_quiet", {63'd0, seen}, 64'd0);
    do_div("u9_3", 32'd9, 32'd3, 1'b0,
           64'h00000000_00000003, 1, -1);

    // reset partway through
    @(negedge clk);
    i_opdata1 = 32'd12345678;
    i_opdata2 = 32'd7;
    i_start   = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    i_rst   = 1'b1;
    i_start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", {63'd0, o_ready}, 64'd0);
    chk("midrst_res", o_result, 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_ready || o_result != 64'd0) seen = 1'b1;
    end
    chk("midrst_quiet", {63'd0, seen}, 64'd0);

    do_div("opchg", 32'd100, 32'd7, 1'b0,
           64'h00000002_0000000E, 1, 5);
    do_div("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0,
           64'h00000000_FFFFFFFF, 1, -1);
    do_div("umax_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
           64'h00000000_00000001, 1, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (rb == 32'd0) rb = 32'd13;
      rs = 1'(i / 2);
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF)
        rb = 32'd3;
      if (rs) begin
        mq = $signed(ra) / $signed(rb);
        mr = $signed(ra) % $signed(rb);
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      do_div("rand", ra, rb, rs, {mr, mq}, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
